// File: rtl/pd_hard_reset_ctrl_if.sv
// Signal bundle between the PD Hard Reset / Cable Reset transmitter and its host/PHY.
// The DUT takes the slave view; the master view drives the request side.
interface pd_hard_reset_ctrl_if #(
    parameter int RETRY_W = 2
);
    // PHY handshake: o_phy_req rises for an attempt and is held until i_phy_done is
    // sampled high in the same cycle (done wins over timeout), then drops on the next cycle.
    logic               i_start;
    logic [7:0]         i_transmit;
    logic               i_phy_done;
    logic [15:0]        i_alert_clr;
    logic               o_phy_req;
    logic [2:0]         o_phy_type;
    logic [7:0]         o_transmit;
    logic [15:0]        o_alert;
    logic [7:0]         o_receive_detect;
    logic [7:0]         o_receive_byte_count;
    logic               o_stop_attempt;
    logic               o_busy;
    logic [RETRY_W-1:0] o_retry_cnt;
    logic [2:0]         o_dbg_state;

    modport slave (
        input  i_start, i_transmit, i_phy_done, i_alert_clr,
        output o_phy_req, o_phy_type, o_transmit, o_alert, o_receive_detect,
               o_receive_byte_count, o_stop_attempt, o_busy, o_retry_cnt, o_dbg_state
    );

    modport master (
        output i_start, i_transmit, i_phy_done, i_alert_clr,
        input  o_phy_req, o_phy_type, o_transmit, o_alert, o_receive_detect,
               o_receive_byte_count, o_stop_attempt, o_busy, o_retry_cnt, o_dbg_state
    );
endinterface

// File: rtl/pd_hard_reset_ctrl.sv
// Protocol-layer Hard Reset / Cable Reset transmitter: PHY req/done handshake with an
// internal tHardResetComplete timer, bounded retries and sticky ALERT/RECEIVE reporting.
module pd_hard_reset_ctrl #(
    parameter int TIMEOUT_CYCLES = 900,
    parameter int CNT_W          = 10,
    parameter int MAX_RETRY      = 2,
    parameter int RETRY_W        = 2
) (
    input  logic             CLK,
    input  logic             reset,
    pd_hard_reset_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SEND        = 3'd1,
        S_RETRY       = 3'd2,
        S_SUCCESS     = 3'd3,
        S_FAIL        = 3'd4,
        S_REPORT_OK   = 3'd5,
        S_REPORT_FAIL = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);
    localparam logic [2:0]         TYPE_HARD    = 3'b101;
    localparam logic [2:0]         TYPE_CABLE   = 3'b110;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [2:0]         type_q, type_d;
    logic [7:0]         transmit_q, transmit_d;
    logic [15:0]        alert_q, alert_d;
    logic [7:0]         rx_detect_q, rx_detect_d;
    logic [7:0]         rx_bytes_q, rx_bytes_d;
    logic               stop_q, stop_d;
    logic [15:0]        set_bits;
    logic               type_valid;
    logic               timeout;

    assign type_valid = (bus.i_transmit[2:0] == TYPE_HARD) || (bus.i_transmit[2:0] == TYPE_CABLE);
    assign timeout    = (cnt_q == TIMEOUT_LAST);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            type_q      <= '0;
            transmit_q  <= '0;
            alert_q     <= '0;
            rx_detect_q <= '0;
            rx_bytes_q  <= '0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            type_q      <= type_d;
            transmit_q  <= transmit_d;
            alert_q     <= alert_d;
            rx_detect_q <= rx_detect_d;
            rx_bytes_q  <= rx_bytes_d;
            stop_q      <= stop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        type_d      = type_q;
        transmit_d  = transmit_q;
        rx_detect_d = rx_detect_q;
        rx_bytes_d  = rx_bytes_q;
        stop_d      = stop_q;
        set_bits    = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    if (type_valid) begin
                        type_d  = bus.i_transmit[2:0];
                        stop_d  = 1'b0;
                        retry_d = '0;
                        cnt_d   = '0;
                        state_d = S_SEND;
                    end else begin
                        // Unsupported TRANSMIT type: report failure without touching the PHY.
                        state_d = S_REPORT_FAIL;
                    end
                end
            end
            S_SEND: begin
                if (!timeout) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bus.i_phy_done) begin
                    state_d = S_SUCCESS;
                end else if (timeout) begin
                    state_d = (retry_q < RETRY_MAX) ? S_RETRY : S_FAIL;
                end
            end
            S_RETRY: begin
                retry_d = retry_q + RETRY_W'(1);
                cnt_d   = '0;
                state_d = S_SEND;
            end
            S_SUCCESS: begin
                transmit_d  = {5'b0, type_q};
                rx_detect_d = '0;
                rx_bytes_d  = (type_q == TYPE_CABLE) ? 8'd1 : 8'd0;
                state_d     = S_REPORT_OK;
            end
            S_FAIL: begin
                stop_d  = 1'b1;
                state_d = S_REPORT_FAIL;
            end
            S_REPORT_OK: begin
                set_bits[6] = 1'b1;
                state_d     = S_IDLE;
            end
            S_REPORT_FAIL: begin
                set_bits[4] = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Sticky ALERT: a set in the same cycle as a clear keeps the bit.
        alert_d = (alert_q & ~bus.i_alert_clr) | set_bits;
    end

    assign bus.o_phy_req            = (state_q == S_SEND);
    assign bus.o_phy_type           = type_q;
    assign bus.o_transmit           = transmit_q;
    assign bus.o_alert              = alert_q;
    assign bus.o_receive_detect     = rx_detect_q;
    assign bus.o_receive_byte_count = rx_bytes_q;
    assign bus.o_stop_attempt       = stop_q;
    assign bus.o_busy               = (state_q != S_IDLE);
    assign bus.o_retry_cnt          = retry_q;
    assign bus.o_dbg_state          = state_q;

endmodule

// File: tb/tb_pd_hard_reset_ctrl.sv
// Directed bench for pd_hard_reset_ctrl: completion snapshots checked against an
// expected queue whenever o_busy falls, plus timing checks in the stimulus thread.
module tb_pd_hard_reset_ctrl;
    localparam int W = 38;

    logic CLK   = 1'b0;
    logic reset = 1'b0;
    always #5 CLK = ~CLK;

    pd_hard_reset_ctrl_if #(.RETRY_W(2)) bus ();

    pd_hard_reset_ctrl #(
        .TIMEOUT_CYCLES(900),
        .CNT_W(10),
        .MAX_RETRY(2),
        .RETRY_W(2)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    logic busy_prev = 1'b0;

    function automatic logic [W-1:0] pack(logic [15:0] a, logic [7:0] t, logic [7:0] bc,
                                          logic st, logic [1:0] r, logic [2:0] ty);
        return {a, t, bc, st, r, ty};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: each completed request (busy falling outside reset) is compared with the queue head.
    always @(negedge CLK) begin
        logic [W-1:0] act;
        logic [W-1:0] exp;
        if (reset && busy_prev && !bus.o_busy) begin
            act = pack(bus.o_alert, bus.o_transmit, bus.o_receive_byte_count,
                       bus.o_stop_attempt, bus.o_retry_cnt, bus.o_phy_type);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL completion_unexpected actual=%0h required=none", act);
            end else begin
                exp = exp_q.pop_front();
                check("completion", act, exp);
            end
        end
        busy_prev <= bus.o_busy;
    end

    task automatic start(logic [7:0] tr);
        bus.i_transmit = tr;
        bus.i_start    = 1'b1;
        tick();
        bus.i_start    = 1'b0;
    endtask

    task automatic clear_alerts();
        bus.i_alert_clr = 16'hFFFF;
        tick();
        bus.i_alert_clr = 16'h0000;
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        while (bus.o_busy && n < budget) begin
            tick();
            n++;
        end
        if (bus.o_busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout actual busy=1 required busy=0", name);
        end
        repeat (2) tick();
    endtask

    task automatic check_all_zero(string name);
        check({name, "_req"},   bus.o_phy_req, 0);
        check({name, "_type"},  bus.o_phy_type, 0);
        check({name, "_tx"},    bus.o_transmit, 0);
        check({name, "_alert"}, bus.o_alert, 0);
        check({name, "_rxdet"}, bus.o_receive_detect, 0);
        check({name, "_rxbc"},  bus.o_receive_byte_count, 0);
        check({name, "_stop"},  bus.o_stop_attempt, 0);
        check({name, "_busy"},  bus.o_busy, 0);
        check({name, "_retry"}, bus.o_retry_cnt, 0);
        check({name, "_state"}, bus.o_dbg_state, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int gap;
        int max_retry;
        int n;
        int runs[$];
        int gaps[$];

        bus.i_start     = 1'b0;
        bus.i_transmit  = 8'h00;
        bus.i_phy_done  = 1'b0;
        bus.i_alert_clr = 16'h0000;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // Hard Reset, done in SEND cycle 10.
        clear_alerts();
        exp_q.push_back(pack(16'h0040, 8'h05, 8'h00, 1'b0, 2'd0, 3'b101));
        start(8'h05);
        check("hr_req_latency", bus.o_phy_req, 1);
        check("hr_type", bus.o_phy_type, 3'b101);
        repeat (10) tick();
        bus.i_phy_done = 1'b1;
        tick();
        bus.i_phy_done = 1'b0;
        check("hr_req_drop", bus.o_phy_req, 0);
        tick();
        check("hr_alert_early", bus.o_alert, 16'h0000);
        tick();
        check("hr_alert_latency", bus.o_alert, 16'h0040);
        wait_idle("hr", 20);

        // Cable Reset, done on the exact timeout cycle.
        clear_alerts();
        exp_q.push_back(pack(16'h0040, 8'h06, 8'h01, 1'b0, 2'd0, 3'b110));
        start(8'h06);
        check("cr_type", bus.o_phy_type, 3'b110);
        repeat (899) tick();
        bus.i_phy_done = 1'b1;
        tick();
        bus.i_phy_done = 1'b0;
        check("cr_done_wins_state", bus.o_dbg_state, 3'd3);
        check("cr_retry", bus.o_retry_cnt, 0);
        wait_idle("cr", 20);

        // No done: three full attempts separated by one-cycle gaps, then failure.
        clear_alerts();
        exp_q.push_back(pack(16'h0010, 8'h06, 8'h01, 1'b1, 2'd2, 3'b101));
        start(8'h05);
        run = 0;
        gap = 0;
        max_retry = 0;
        for (int k = 0; k < 3000 && bus.o_busy; k++) begin
            if (bus.o_phy_req) begin
                if (gap > 0) begin
                    gaps.push_back(gap);
                    gap = 0;
                end
                run++;
            end else begin
                if (run > 0) begin
                    runs.push_back(run);
                    run = 0;
                end
                gap++;
            end
            if (int'(bus.o_retry_cnt) > max_retry) max_retry = int'(bus.o_retry_cnt);
            tick();
        end
        check("nd_attempts", runs.size(), 3);
        foreach (runs[i]) check("nd_attempt_len", runs[i], 900);
        check("nd_gaps", gaps.size(), 2);
        foreach (gaps[i]) check("nd_gap_len", gaps[i], 1);
        check("nd_max_retry", max_retry, 2);
        check("nd_stop", bus.o_stop_attempt, 1);
        check("nd_alert", bus.o_alert, 16'h0010);
        wait_idle("nd", 20);

        // Invalid type: no PHY request, failure alert within two cycles.
        clear_alerts();
        exp_q.push_back(pack(16'h0010, 8'h06, 8'h01, 1'b1, 2'd2, 3'b101));
        start(8'h00);
        check("inv_req_c1", bus.o_phy_req, 0);
        tick();
        check("inv_req_c2", bus.o_phy_req, 0);
        check("inv_alert", bus.o_alert, 16'h0010);
        wait_idle("inv", 20);

        // Clear arriving in the same cycle REPORT_OK sets bit6.
        clear_alerts();
        exp_q.push_back(pack(16'h0040, 8'h05, 8'h00, 1'b0, 2'd0, 3'b101));
        start(8'h05);
        repeat (3) tick();
        bus.i_phy_done = 1'b1;
        tick();
        bus.i_phy_done = 1'b0;
        tick();
        check("clr_in_report_ok", bus.o_dbg_state, 3'd5);
        bus.i_alert_clr = 16'h0040;
        tick();
        bus.i_alert_clr = 16'h0000;
        check("clr_set_wins", bus.o_alert, 16'h0040);
        bus.i_alert_clr = 16'h0040;
        tick();
        bus.i_alert_clr = 16'h0000;
        check("clr_next_cycle", bus.o_alert, 16'h0000);
        wait_idle("clr", 20);

        // Asynchronous reset in the middle of SEND, then a fresh full-length attempt.
        clear_alerts();
        start(8'h06);
        repeat (400) tick();
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        #3;
        reset = 1'b1;
        tick();
        exp_q.push_back(pack(16'h0040, 8'h05, 8'h00, 1'b0, 2'd1, 3'b101));
        start(8'h05);
        n = 0;
        while (bus.o_phy_req && n < 1000) begin
            n++;
            tick();
        end
        check("rst_fresh_attempt_len", n, 900);
        tick();
        check("rst_retry_req", bus.o_phy_req, 1);
        bus.i_phy_done = 1'b1;
        tick();
        bus.i_phy_done = 1'b0;
        wait_idle("rst", 20);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
